banco_registros_param: RTL and testbench

BANCO_REGISTROS_PARAM -- requirements
Module: banco_registros_param

---
 rtl/banco_registros_param_pkg.sv | 19 +
 rtl/banco_registros_param_puerto_lectura.sv | 38 +++
 rtl/banco_registros_param.sv | 126 ++++++++++++
 tb/tb_banco_registros_param.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_registros_param_pkg.sv
// Shared definitions for the parameterised register bank: sweep FSM states,
// default geometry and the address-width helper.
package banco_registros_param_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BORRA = 2'd1,
        FIN   = 2'd2
    } estado_t;

    localparam int ANCHO_DEF = 32;
    localparam int PROF_DEF  = 32;

    // Address width needed to index prof registers (at least one bit).
    function automatic int calc_dir(input int prof);
        return (prof > 1) ? $clog2(prof) : 1;
    endfunction

endpackage

// File: rtl/banco_registros_param_puerto_lectura.sv
// One combinational read port: selects a register from the flattened bank,
// forwards same-cycle write data, and forces zero for unmapped addresses
// and for a hardwired register 0.
module puerto_lectura
    import banco_registros_param_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int PROF    = PROF_DEF,
    parameter int DIR     = calc_dir(PROF_DEF),
    parameter int R0_CERO = 1
) (
    input  logic [DIR-1:0]        dir,
    input  logic [PROF*ANCHO-1:0] tabla,
    input  logic                  escritura,
    input  logic [DIR-1:0]        dir_write,
    input  logic [ANCHO-1:0]      dato_nuevo,
    output logic [ANCHO-1:0]      dato
);

    logic fuera;
    logic cero;

    assign fuera = (int'(dir) >= PROF);
    assign cero  = (R0_CERO != 0) && (dir == '0);

    // Zero masking wins, then the bypass of a qualified write, then storage.
    always_comb begin
        dato = '0;
        if (!(fuera || cero)) begin
            if (escritura && (dir == dir_write)) begin
                dato = dato_nuevo;
            end else begin
                dato = tabla[int'(dir)*ANCHO +: ANCHO];
            end
        end
    end

endmodule

// File: rtl/banco_registros_param.sv
// Parameterised register bank with NLECT combinational read ports, one
// write port with write-through bypass, and a sequential clear sweep that
// zeroes one register per cycle.
module banco_registros_param
    import banco_registros_param_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int PROF    = PROF_DEF,
    parameter int DIR     = calc_dir(PROF),
    parameter int NLECT   = 2,
    parameter int R0_CERO = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RWEN,
    input  logic [DIR-1:0]         DirWrite,
    input  logic [ANCHO-1:0]       DatoNuevo,
    input  logic [NLECT*DIR-1:0]   Dir,
    output logic [NLECT*ANCHO-1:0] Dato,
    input  logic                   CLR_REQ,
    output logic                   CLR_BUSY,
    output logic                   CLR_DONE
);

    localparam logic [DIR-1:0] ULTIMO = DIR'(PROF - 1);

    estado_t               estado_reg;
    estado_t               estado_next;
    logic [DIR-1:0]        cnt_reg;
    logic [DIR-1:0]        cnt_next;
    logic [PROF*ANCHO-1:0] tabla;
    logic                  dir_ok;
    logic                  r0_bloq;
    logic                  escritura;

    // A write is only honoured while idle, to a mapped, writable register.
    // Reset also suppresses it so the bypass cannot leak data while RST=1.
    assign dir_ok    = (int'(DirWrite) < PROF);
    assign r0_bloq   = (R0_CERO != 0) && (DirWrite == '0);
    assign escritura = RWEN && (estado_reg == IDLE) && dir_ok && !r0_bloq && !RST;

    // Sweep FSM state and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado_reg <= IDLE;
            cnt_reg    <= '0;
        end else begin
            estado_reg <= estado_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state and status outputs; the counter stops at PROF-1 so it never
    // walks into unmapped addresses for non power-of-two depths.
    always_comb begin
        estado_next = estado_reg;
        cnt_next    = cnt_reg;
        CLR_BUSY    = 1'b0;
        CLR_DONE    = 1'b0;
        case (estado_reg)
            IDLE: begin
                if (CLR_REQ) begin
                    estado_next = BORRA;
                    cnt_next    = '0;
                end
            end
            BORRA: begin
                CLR_BUSY = 1'b1;
                if (cnt_reg == ULTIMO) begin
                    estado_next = FIN;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FIN: begin
                CLR_DONE    = 1'b1;
                estado_next = IDLE;
            end
            default: begin
                estado_next = IDLE;
                cnt_next    = '0;
            end
        endcase
    end

    // Storage: each register takes either the qualified write or the sweep zero.
    generate
        for (genvar gi = 0; gi < PROF; gi++) begin : g_reg
            logic [ANCHO-1:0] valor_reg;

            // Per-register update: async clear, write port, or sweep clear.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    valor_reg <= '0;
                end else if (escritura && (int'(DirWrite) == gi)) begin
                    valor_reg <= DatoNuevo;
                end else if ((estado_reg == BORRA) && (int'(cnt_reg) == gi)) begin
                    valor_reg <= '0;
                end
            end

            assign tabla[gi*ANCHO +: ANCHO] = valor_reg;
        end
    endgenerate

    // Independent read ports.
    generate
        for (genvar gi = 0; gi < NLECT; gi++) begin : g_lect
            puerto_lectura #(
                .ANCHO   (ANCHO),
                .PROF    (PROF),
                .DIR     (DIR),
                .R0_CERO (R0_CERO)
            ) u_puerto (
                .dir        (Dir[gi*DIR +: DIR]),
                .tabla      (tabla),
                .escritura  (escritura),
                .dir_write  (DirWrite),
                .dato_nuevo (DatoNuevo),
                .dato       (Dato[gi*ANCHO +: ANCHO])
            );
        end
    endgenerate

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: a default bank (32x32, 2 ports, r0 hardwired)
// and a 20-deep, 3-port bank without r0 forcing share the write/clear stimulus.
// A behavioural model tracks contents and sweep progress; every cycle all
// outputs of both banks are compared, plus hand-computed directed checks.
module tb_banco_registros_param;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RWEN = 1'b0;
    logic        CLR_REQ = 1'b0;
    logic [4:0]  DirWrite = '0;
    logic [31:0] DatoNuevo = '0;
    logic [9:0]  dir_a = '0;
    logic [63:0] dato_a;
    logic        busy_a, done_a;
    logic [14:0] dir_b = '0;
    logic [95:0] dato_b;
    logic        busy_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 CLK = ~CLK;

    banco_registros_param #(
        .ANCHO(32), .PROF(32), .NLECT(2), .R0_CERO(1)
    ) dut_a (
        .CLK(CLK), .RST(RST), .RWEN(RWEN), .DirWrite(DirWrite),
        .DatoNuevo(DatoNuevo), .Dir(dir_a), .Dato(dato_a),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(busy_a), .CLR_DONE(done_a)
    );

    banco_registros_param #(
        .ANCHO(32), .PROF(20), .NLECT(3), .R0_CERO(0)
    ) dut_b (
        .CLK(CLK), .RST(RST), .RWEN(RWEN), .DirWrite(DirWrite),
        .DatoNuevo(DatoNuevo), .Dir(dir_b), .Dato(dato_b),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(busy_b), .CLR_DONE(done_b)
    );

    // ---------------- behavioural model ----------------
    int          prof_m [2] = '{32, 20};
    bit          r0_m   [2] = '{1'b1, 1'b0};
    int          nl_m   [2] = '{2, 3};
    logic [31:0] mem    [2][32];
    // Sweep progress: 0 idle; p in 1..prof means entry p-1 is cleared at the
    // next edge (busy); prof+1 is the single done cycle.
    int          ph     [2] = '{0, 0};

    function automatic bit wr_ok(int w);
        return RWEN && !RST && (ph[w] == 0) && (int'(DirWrite) < prof_m[w])
               && !(r0_m[w] && (DirWrite == 5'd0));
    endfunction

    function automatic logic [31:0] exp_rd(int w, int a);
        if (RST) return 32'd0;
        if (a >= prof_m[w]) return 32'd0;
        if (r0_m[w] && a == 0) return 32'd0;
        if (wr_ok(w) && a == int'(DirWrite)) return DatoNuevo;
        return mem[w][a];
    endfunction

    always @(posedge CLK or posedge RST) begin
        for (int w = 0; w < 2; w++) begin
            if (RST) begin
                ph[w] = 0;
                for (int i = 0; i < 32; i++) mem[w][i] = 32'd0;
            end else if (ph[w] == 0) begin
                if (wr_ok(w)) mem[w][DirWrite] = DatoNuevo;
                if (CLR_REQ) ph[w] = 1;
            end else if (ph[w] <= prof_m[w]) begin
                mem[w][ph[w]-1] = 32'd0;
                ph[w] = ph[w] + 1;
            end else begin
                ph[w] = 0;
            end
        end
    end

    task automatic chk(string nm, logic [95:0] got, logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge CLK);
        #2;
        if (chk_en) begin
            for (int w = 0; w < 2; w++) begin
                logic eb, ed, gb, gd;
                eb = !RST && (ph[w] >= 1) && (ph[w] <= prof_m[w]);
                ed = !RST && (ph[w] == prof_m[w] + 1);
                gb = (w == 0) ? busy_a : busy_b;
                gd = (w == 0) ? done_a : done_b;
                chk($sformatf("busy[%0d] t=%0t", w, $time), 96'(gb), 96'(eb));
                chk($sformatf("done[%0d] t=%0t", w, $time), 96'(gd), 96'(ed));
                for (int k = 0; k < nl_m[w]; k++) begin
                    int a;
                    logic [31:0] g;
                    a = (w == 0) ? int'(dir_a[k*5 +: 5]) : int'(dir_b[k*5 +: 5]);
                    g = (w == 0) ? dato_a[k*32 +: 32] : dato_b[k*32 +: 32];
                    chk($sformatf("dato[%0d][%0d] addr=%0d t=%0t", w, k, a, $time),
                        96'(g), 96'(exp_rd(w, a)));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (ph[0] == 0 && ph[1] == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("wait_idle_timeout", 96'(ok), 96'd1);
    endtask

    task automatic fill();
        for (int a = 0; a < 32; a++) begin
            step();
            RWEN = 1'b1;
            DirWrite = 5'(a);
            DatoNuevo = $urandom | 32'd1;
        end
        step();
        RWEN = 1'b0;
    endtask

    initial begin
        int nb_a, nd_a, nb_b, nd_b;
        logic [31:0] v;

        // Reset held; a write attempt must not leak through the bypass.
        repeat (2) step();
        chk_en = 1'b1;
        RWEN = 1'b1; DirWrite = 5'd4; DatoNuevo = 32'd55;
        dir_a = {5'd4, 5'd4}; dir_b = {5'd4, 5'd4, 5'd4};
        #3;
        chk("rst_dato_a", 96'(dato_a), 96'd0);
        chk("rst_dato_b", 96'(dato_b), 96'd0);
        chk("rst_busy_a", 96'(busy_a), 96'd0);

        // Release and write on the very first edge.
        step();
        RST = 1'b0;
        RWEN = 1'b1; DirWrite = 5'd5; DatoNuevo = 32'd10;
        dir_a = {5'd0, 5'd0};
        step();
        RWEN = 1'b0;
        dir_a = {5'd0, 5'd5};
        #3 chk("wr5_read_next", 96'(dato_a[31:0]), 96'd10);

        // Bypass before the edge.
        step();
        RWEN = 1'b1; DirWrite = 5'd7; DatoNuevo = 32'd20;
        dir_a = {5'd7, 5'd0}; dir_b = {5'd0, 5'd7, 5'd0};
        #3;
        chk("bypass_a_port1", 96'(dato_a[63:32]), 96'd20);
        chk("bypass_b_port1", 96'(dato_b[63:32]), 96'd20);

        // Register 0: hardwired on A, ordinary on B.
        step();
        RWEN = 1'b1; DirWrite = 5'd0; DatoNuevo = 32'hFFFF_FFFF;
        dir_a = {5'd0, 5'd0}; dir_b = {5'd0, 5'd0, 5'd0};
        #3;
        chk("r0_bypass_a", 96'(dato_a), 96'd0);
        chk("r0_bypass_b", 96'(dato_b[31:0]), 96'hFFFF_FFFF);
        step();
        RWEN = 1'b0;
        #3;
        chk("r0_read_a", 96'(dato_a), 96'd0);
        chk("r0_read_b", 96'(dato_b[31:0]), 96'hFFFF_FFFF);

        // Randomised traffic with occasional clear requests.
        for (int c = 0; c < 400; c++) begin
            step();
            RWEN = ($urandom_range(0, 3) != 0);
            DirWrite = 5'($urandom);
            DatoNuevo = $urandom;
            dir_a = 10'($urandom);
            dir_b = 15'($urandom);
            if ($urandom_range(0, 3) == 0) dir_a[4:0] = DirWrite;
            if ($urandom_range(0, 3) == 0) dir_b[9:5] = DirWrite;
            CLR_REQ = ($urandom_range(0, 59) == 0);
        end
        step();
        RWEN = 1'b0; CLR_REQ = 1'b0;
        wait_idle();

        // Full sweep with a write to reg 3 attempted throughout it.
        fill();
        step();
        CLR_REQ = 1'b1;
        step();
        CLR_REQ = 1'b0;
        nb_a = 0; nd_a = 0; nb_b = 0; nd_b = 0;
        dir_a = {5'd3, 5'd3};
        for (int c = 0; c < 60; c++) begin
            RWEN = (ph[0] != 0);
            DirWrite = 5'd3;
            DatoNuevo = 32'hDEAD_BEEF;
            #3;
            nb_a += int'(busy_a); nd_a += int'(done_a);
            nb_b += int'(busy_b); nd_b += int'(done_b);
            step();
        end
        RWEN = 1'b0;
        chk("sweep_busy_a", 96'(nb_a), 96'd32);
        chk("sweep_done_a", 96'(nd_a), 96'd1);
        chk("sweep_busy_b", 96'(nb_b), 96'd20);
        chk("sweep_done_b", 96'(nd_b), 96'd1);
        for (int a = 0; a < 32; a++) begin
            step();
            dir_a = {5'(a), 5'(a)};
            #3 chk($sformatf("cleared_a reg%0d", a), 96'(dato_a), 96'd0);
        end

        // Write and clear request in the same idle cycle.
        step();
        RWEN = 1'b1; DirWrite = 5'd9; DatoNuevo = 32'h1234_5678; CLR_REQ = 1'b1;
        step();
        RWEN = 1'b0; CLR_REQ = 1'b0;
        dir_a = {5'd9, 5'd9};
        #3;
        chk("wr_then_clr_data", 96'(dato_a[31:0]), 96'h1234_5678);
        chk("wr_then_clr_busy", 96'(busy_a), 96'd1);
        wait_idle();
        step();
        #3 chk("wr_then_clr_cleared", 96'(dato_a[31:0]), 96'd0);

        // Reset during the tenth sweep cycle.
        fill();
        step();
        CLR_REQ = 1'b1;
        step();
        CLR_REQ = 1'b0;
        dir_a = {5'd31, 5'd30};
        repeat (9) step();
        RST = 1'b1;
        #3;
        chk("abort_busy_a", 96'(busy_a), 96'd0);
        chk("abort_done_a", 96'(done_a), 96'd0);
        chk("abort_dato_a", 96'(dato_a), 96'd0);
        chk("abort_dato_b", 96'(dato_b), 96'd0);
        step();
        RST = 1'b0;
        nd_a = 0; nb_a = 0;
        for (int c = 0; c < 40; c++) begin
            #3;
            nd_a += int'(done_a) + int'(done_b);
            nb_a += int'(busy_a) + int'(busy_b);
            step();
        end
        chk("abort_no_done", 96'(nd_a), 96'd0);
        chk("abort_idle", 96'(nb_a), 96'd0);

        // Non power-of-two depth: top entry and unmapped addresses.
        step();
        RWEN = 1'b1; DirWrite = 5'd19; DatoNuevo = 32'hCAFE_F00D;
        step();
        RWEN = 1'b0;
        dir_b = {5'd31, 5'd20, 5'd19};
        #3 chk("b_19_20_31", 96'(dato_b), {32'd0, 32'd0, 32'hCAFE_F00D});
        step();
        v = 32'h5A5A_0001;
        RWEN = 1'b1; DirWrite = 5'd25; DatoNuevo = v;
        dir_a = {5'd25, 5'd0}; dir_b = {5'd0, 5'd0, 5'd25};
        #3;
        chk("b_unmapped_bypass", 96'(dato_b[31:0]), 96'd0);
        chk("a_25_bypass", 96'(dato_a[63:32]), 96'(v));

        // Clear request held high: back-to-back sweeps.
        step();
        RWEN = 1'b0;
        CLR_REQ = 1'b1;
        repeat (80) step();
        CLR_REQ = 1'b0;
        wait_idle();

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
